// File: rtl/bt_radio_seq.sv
// Bluetooth radio burst sequencer: retune, PLL settle, then 1 Mb/s TX/RX bit transfer.
// Optional data whitening (x^7+x^4+1) is enabled by defining BT_RADIO_SEQ_WHITEN_EN.
module bt_radio_seq #(
  parameter int SETTLE_CYC = 600
) (
  input  logic       clk_6M,
  input  logic       rstz,
  input  logic       start_p,
  input  logic       stop_p,
  input  logic       dir,
  input  logic [6:0] chan,
  input  logic [9:0] nbits,
  input  logic [7:0] txbyte,
  input  logic       txbyte_vld,
  output logic       txbyte_rdy,
  output logic [7:0] rxbyte,
  output logic       rxbyte_vld,
  output logic [6:0] k,
  output logic       loadfreq_p,
  output logic       txen,
  output logic       rxen,
  output logic       txbitin,
  input  logic       rxbitout,
  output logic       busy,
  output logic       done_p,
  output logic       err_p
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_XFER, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_dir, r_err, r_rxvld, r_buf_full;
  logic [6:0]  r_k;
  logic [9:0]  r_nbits, r_bitcnt;
  logic [11:0] r_cnt;
  logic [2:0]  r_phase;
  logic [7:0]  r_buf, r_txsh, r_rxsh, r_rxbyte;

  logic        w_start_ok, w_bit_end, w_last, w_boundary, w_need, w_underrun;
  logic        w_white, w_rxbit;
  logic [9:0]  w_nxt_idx;
  logic [7:0]  w_rx_asm;

  assign w_start_ok = (chan <= 7'd78) && (nbits != 10'd0);
  assign w_bit_end  = (r_phase == 3'd5);
  assign w_last     = (r_bitcnt == r_nbits - 10'd1);
  assign w_nxt_idx  = r_bitcnt + 10'd1;
  // A bit boundary is either the SETTLE->XFER edge or the end of a non-final bit.
  assign w_boundary = ((r_state == S_SETTLE) && (r_cnt == 12'd0)) ||
                      ((r_state == S_XFER) && w_bit_end && !w_last);
  assign w_need     = (r_state == S_SETTLE) || (w_nxt_idx[2:0] == 3'd0);
  assign w_underrun = w_boundary && w_need && r_dir && !r_buf_full;

`ifdef BT_RADIO_SEQ_WHITEN_EN
  logic [6:0] r_lfsr;
  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      r_lfsr <= 7'd0;
    end else if (r_state == S_LOAD) begin
      r_lfsr <= {1'b1, r_k[5:0]};
    end else if ((r_state == S_XFER) && w_bit_end) begin
      r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[3]};
    end
  end
  assign w_white = r_lfsr[6];
`else
  assign w_white = 1'b0;
`endif

  assign w_rxbit  = rxbitout ^ w_white;
  assign w_rx_asm = r_rxsh | (8'(w_rxbit) << r_bitcnt[2:0]);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start_p && w_start_ok) w_next = S_LOAD;
      S_LOAD:   w_next = S_SETTLE;
      S_SETTLE: if (r_cnt == 12'd0) w_next = S_XFER;
      S_XFER:   if (w_bit_end && w_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_underrun) w_next = S_IDLE;
    if (stop_p && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  assign busy       = (r_state != S_IDLE);
  assign loadfreq_p = (r_state == S_LOAD);
  assign txen       = (r_state == S_XFER) && r_dir;
  assign rxen       = (r_state == S_XFER) && !r_dir;
  assign done_p     = (r_state == S_DONE);
  assign txbitin    = txen && (r_txsh[0] ^ w_white);
  assign txbyte_rdy = busy && r_dir && !r_buf_full;
  assign err_p      = r_err;
  assign k          = r_k;
  assign rxbyte     = r_rxbyte;
  assign rxbyte_vld = r_rxvld;

  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      r_state    <= S_IDLE;
      r_dir      <= 1'b0;
      r_err      <= 1'b0;
      r_rxvld    <= 1'b0;
      r_buf_full <= 1'b0;
      r_k        <= 7'd0;
      r_nbits    <= 10'd0;
      r_bitcnt   <= 10'd0;
      r_cnt      <= 12'd0;
      r_phase    <= 3'd0;
      r_buf      <= 8'd0;
      r_txsh     <= 8'd0;
      r_rxsh     <= 8'd0;
      r_rxbyte   <= 8'd0;
    end else begin
      r_state <= w_next;
      r_err   <= 1'b0;
      r_rxvld <= 1'b0;
      if (txbyte_vld && txbyte_rdy) begin
        r_buf      <= txbyte;
        r_buf_full <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (start_p && w_start_ok) begin
            r_dir      <= dir;
            r_k        <= chan;
            r_nbits    <= nbits;
            r_buf_full <= 1'b0;
          end else if (start_p) begin
            r_err <= 1'b1;
          end
        end
        S_LOAD:   r_cnt <= 12'(SETTLE_CYC - 1);
        S_SETTLE: begin
          r_cnt    <= r_cnt - 12'd1;
          r_phase  <= 3'd0;
          r_bitcnt <= 10'd0;
          r_rxsh   <= 8'd0;
        end
        S_XFER: begin
          r_phase <= w_bit_end ? 3'd0 : r_phase + 3'd1;
          if (w_bit_end) r_bitcnt <= w_nxt_idx;
          // Mid-bit sample; a byte (or the final partial byte) is emitted on its last sample.
          if (!r_dir && (r_phase == 3'd3) && !stop_p) begin
            if ((r_bitcnt[2:0] == 3'd7) || w_last) begin
              r_rxbyte <= w_rx_asm;
              r_rxvld  <= 1'b1;
              r_rxsh   <= 8'd0;
            end else begin
              r_rxsh <= w_rx_asm;
            end
          end
        end
        default: ;
      endcase
      if (w_boundary && w_need && r_dir && r_buf_full) begin
        r_txsh     <= r_buf;
        r_buf_full <= 1'b0;
      end else if ((r_state == S_XFER) && w_bit_end) begin
        r_txsh <= r_txsh >> 1;
      end
      if (w_underrun && !stop_p) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bt_radio_seq.sv
// Directed bench for bt_radio_seq; cycle 0 is the cycle in which start_p is driven.
module tb_bt_radio_seq;
  logic       clk_6M = 1'b0, rstz = 1'b0, start_p = 1'b0, stop_p = 1'b0, dir = 1'b0;
  logic [6:0] chan = 7'd0;
  logic [9:0] nbits = 10'd0;
  logic [7:0] txbyte = 8'd0;
  logic       txbyte_vld = 1'b0, rxbitout = 1'b0;
  logic       txbyte_rdy, rxbyte_vld, loadfreq_p, txen, rxen, txbitin, busy, done_p, err_p;
  logic [7:0] rxbyte;
  logic [6:0] k;
  int n_checks = 0, n_fail = 0;

  bt_radio_seq #(.SETTLE_CYC(600)) dut (
    .clk_6M(clk_6M), .rstz(rstz), .start_p(start_p), .stop_p(stop_p), .dir(dir),
    .chan(chan), .nbits(nbits), .txbyte(txbyte), .txbyte_vld(txbyte_vld),
    .txbyte_rdy(txbyte_rdy), .rxbyte(rxbyte), .rxbyte_vld(rxbyte_vld), .k(k),
    .loadfreq_p(loadfreq_p), .txen(txen), .rxen(rxen), .txbitin(txbitin),
    .rxbitout(rxbitout), .busy(busy), .done_p(done_p), .err_p(err_p)
  );

  always #5 clk_6M = ~clk_6M;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_6M);
    #1;
  endtask

  task automatic test_reset;
    logic [23:0] outs;
    rstz = 1'b0;
    step(3);
    outs = {busy, loadfreq_p, txen, rxen, txbitin, txbyte_rdy, rxbyte_vld, done_p, err_p, k, rxbyte};
    n_checks++;
    if (outs !== 24'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 000000", outs); end
    rstz = 1'b1;
    step(1);
  endtask

  task automatic test_tx_basic;
    logic [7:0] pat;
    pat = 8'hA5;
    start_p = 1'b1; dir = 1'b1; chan = 7'd5; nbits = 10'd8;
    step(1); start_p = 1'b0;
    n_checks++;
    if (loadfreq_p !== 1'b1 || k !== 7'd5) begin n_fail++; $display("FAIL tx_load: loadfreq=%b k=%0d want 1/5", loadfreq_p, k); end
    n_checks++;
    if (txbyte_rdy !== 1'b1) begin n_fail++; $display("FAIL tx_rdy_prefill: got %b want 1", txbyte_rdy); end
    txbyte = 8'hA5; txbyte_vld = 1'b1;
    step(1); txbyte_vld = 1'b0;
    n_checks++;
    if (loadfreq_p !== 1'b0 || txbyte_rdy !== 1'b0) begin n_fail++; $display("FAIL tx_after_load: loadfreq=%b rdy=%b want 0/0", loadfreq_p, txbyte_rdy); end
    step(599);
    n_checks++;
    if (txen !== 1'b0) begin n_fail++; $display("FAIL tx_en_cycle601: got %b want 0", txen); end
    step(1);
    for (int b = 0; b < 8; b++) begin
      for (int p = 0; p < 6; p++) begin
        n_checks++;
        if (txen !== 1'b1 || rxen !== 1'b0 || txbitin !== pat[b])
          begin n_fail++; $display("FAIL tx_bit%0d_ph%0d: txen=%b rxen=%b bit=%b want 1/0/%b", b, p, txen, rxen, txbitin, pat[b]); end
        step(1);
      end
    end
    n_checks++;
    if (done_p !== 1'b1 || txen !== 1'b0 || txbitin !== 1'b0) begin n_fail++; $display("FAIL tx_done650: done=%b txen=%b bit=%b want 1/0/0", done_p, txen, txbitin); end
    step(1);
    n_checks++;
    if (done_p !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL tx_idle651: done=%b busy=%b want 0/0", done_p, busy); end
  endtask

  task automatic test_rx_partial;
    logic [11:0] pat;
    logic        exp_vld;
    pat = 12'hF3C;
    start_p = 1'b1; dir = 1'b0; chan = 7'd78; nbits = 10'd12;
    step(1); start_p = 1'b0;
    n_checks++;
    if (loadfreq_p !== 1'b1 || k !== 7'd78 || txbyte_rdy !== 1'b0) begin n_fail++; $display("FAIL rx_load: loadfreq=%b k=%0d rdy=%b want 1/78/0", loadfreq_p, k, txbyte_rdy); end
    step(600);
    n_checks++;
    if (rxen !== 1'b0) begin n_fail++; $display("FAIL rx_en_cycle601: got %b want 0", rxen); end
    step(1);
    for (int b = 0; b < 12; b++) begin
      for (int p = 0; p < 6; p++) begin
        if (p == 0) rxbitout = pat[b];
        exp_vld = (p == 4) && (b == 7 || b == 11);
        n_checks++;
        if (rxen !== 1'b1 || txen !== 1'b0 || rxbyte_vld !== exp_vld)
          begin n_fail++; $display("FAIL rx_bit%0d_ph%0d: rxen=%b txen=%b vld=%b want 1/0/%b", b, p, rxen, txen, rxbyte_vld, exp_vld); end
        if (exp_vld) begin
          n_checks++;
          if (rxbyte !== ((b == 7) ? 8'h3C : 8'h0F))
            begin n_fail++; $display("FAIL rx_byte_at_bit%0d: got %h want %h", b, rxbyte, (b == 7) ? 8'h3C : 8'h0F); end
        end
        step(1);
      end
    end
    n_checks++;
    if (done_p !== 1'b1 || rxen !== 1'b0) begin n_fail++; $display("FAIL rx_done: done=%b rxen=%b want 1/0", done_p, rxen); end
    step(1);
    rxbitout = 1'b0;
  endtask

  task automatic test_bad_start;
    start_p = 1'b1; dir = 1'b1; chan = 7'd79; nbits = 10'd8;
    step(1); start_p = 1'b0;
    n_checks++;
    if (err_p !== 1'b1 || busy !== 1'b0 || loadfreq_p !== 1'b0 || k !== 7'd78)
      begin n_fail++; $display("FAIL bad_chan: err=%b busy=%b loadfreq=%b k=%0d want 1/0/0/78", err_p, busy, loadfreq_p, k); end
    step(1);
    n_checks++;
    if (err_p !== 1'b0 || busy !== 1'b0 || loadfreq_p !== 1'b0) begin n_fail++; $display("FAIL bad_chan_after: err=%b busy=%b loadfreq=%b want 0/0/0", err_p, busy, loadfreq_p); end
    start_p = 1'b1; chan = 7'd3; nbits = 10'd0;
    step(1); start_p = 1'b0;
    n_checks++;
    if (err_p !== 1'b1 || busy !== 1'b0 || loadfreq_p !== 1'b0) begin n_fail++; $display("FAIL bad_nbits: err=%b busy=%b loadfreq=%b want 1/0/0", err_p, busy, loadfreq_p); end
    step(1);
    n_checks++;
    if (err_p !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bad_nbits_after: err=%b busy=%b want 0/0", err_p, busy); end
  endtask

  task automatic test_underrun;
    start_p = 1'b1; dir = 1'b1; chan = 7'd10; nbits = 10'd16;
    step(1); start_p = 1'b0;
    txbyte = 8'hFF; txbyte_vld = 1'b1;
    step(1); txbyte_vld = 1'b0;
    step(600);
    n_checks++;
    if (txen !== 1'b1 || txbitin !== 1'b1) begin n_fail++; $display("FAIL ur_first_bit: txen=%b bit=%b want 1/1", txen, txbitin); end
    step(47);
    n_checks++;
    if (txen !== 1'b1 || err_p !== 1'b0) begin n_fail++; $display("FAIL ur_cycle649: txen=%b err=%b want 1/0", txen, err_p); end
    step(1);
    n_checks++;
    if (err_p !== 1'b1 || txen !== 1'b0 || busy !== 1'b0 || done_p !== 1'b0)
      begin n_fail++; $display("FAIL ur_cycle650: err=%b txen=%b busy=%b done=%b want 1/0/0/0", err_p, txen, busy, done_p); end
    step(1);
    n_checks++;
    if (err_p !== 1'b0 || done_p !== 1'b0) begin n_fail++; $display("FAIL ur_cycle651: err=%b done=%b want 0/0", err_p, done_p); end
  endtask

  task automatic test_stop_reset;
    logic [23:0] outs;
    int          nvld;
    stop_p = 1'b1;
    step(1); stop_p = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || err_p !== 1'b0) begin n_fail++; $display("FAIL stop_in_idle: busy=%b err=%b want 0/0", busy, err_p); end
    start_p = 1'b1; stop_p = 1'b1; dir = 1'b0; chan = 7'd1; nbits = 10'd16;
    step(1); start_p = 1'b0; stop_p = 1'b0;
    n_checks++;
    if (loadfreq_p !== 1'b1 || k !== 7'd1) begin n_fail++; $display("FAIL start_with_stop: loadfreq=%b k=%0d want 1/1", loadfreq_p, k); end
    step(3);
    start_p = 1'b1; chan = 7'd79;
    step(1); start_p = 1'b0;
    n_checks++;
    if (err_p !== 1'b0 || busy !== 1'b1 || k !== 7'd1) begin n_fail++; $display("FAIL start_while_busy: err=%b busy=%b k=%0d want 0/1/1", err_p, busy, k); end
    stop_p = 1'b1;
    step(1); stop_p = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || rxen !== 1'b0 || done_p !== 1'b0 || err_p !== 1'b0)
      begin n_fail++; $display("FAIL stop_settle: busy=%b rxen=%b done=%b err=%b want 0/0/0/0", busy, rxen, done_p, err_p); end
    step(700);
    n_checks++;
    if (busy !== 1'b0 || rxen !== 1'b0) begin n_fail++; $display("FAIL stop_stays_idle: busy=%b rxen=%b want 0/0", busy, rxen); end
    start_p = 1'b1; dir = 1'b0; chan = 7'd2; nbits = 10'd16; rxbitout = 1'b1;
    step(1); start_p = 1'b0;
    step(620);
    n_checks++;
    if (rxen !== 1'b1) begin n_fail++; $display("FAIL rx_before_reset: rxen=%b want 1", rxen); end
    rstz = 1'b0;
    step(1);
    outs = {busy, loadfreq_p, txen, rxen, txbitin, txbyte_rdy, rxbyte_vld, done_p, err_p, k, rxbyte};
    n_checks++;
    if (outs !== 24'd0) begin n_fail++; $display("FAIL reset_mid_rx: got %h want 000000", outs); end
    rstz = 1'b1;
    nvld = 0;
    for (int i = 0; i < 100; i++) begin
      if (rxbyte_vld === 1'b1 || busy === 1'b1 || done_p === 1'b1) nvld++;
      step(1);
    end
    n_checks++;
    if (nvld !== 0) begin n_fail++; $display("FAIL after_reset_quiet: active cycles=%0d want 0", nvld); end
    rxbitout = 1'b0;
  endtask

`ifdef BT_RADIO_SEQ_WHITEN_EN
  task automatic test_whiten;
    logic [7:0] pat;
    pat = 8'h81;
    start_p = 1'b1; dir = 1'b1; chan = 7'd0; nbits = 10'd8;
    step(1); start_p = 1'b0;
    txbyte = 8'h00; txbyte_vld = 1'b1;
    step(1); txbyte_vld = 1'b0;
    step(600);
    for (int b = 0; b < 8; b++) begin
      n_checks++;
      if (txbitin !== pat[b]) begin n_fail++; $display("FAIL whiten_bit%0d: got %b want %b", b, txbitin, pat[b]); end
      step(6);
    end
    step(1);
  endtask
`endif

  initial begin
    test_reset();
    test_tx_basic();
    test_rx_partial();
    test_bad_start();
    test_underrun();
    test_stop_reset();
`ifdef BT_RADIO_SEQ_WHITEN_EN
    test_whiten();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bt_radio_seq.md
BT_RADIO_SEQ -- requirements
Module: bt_radio_seq

Interface
REQ-001 Parameter: SETTLE_CYC, default 600, PLL settle wait in clk_6M cycles (100 us at 6 MHz), legal range 1..4095.
REQ-002 Port: clk_6M  in  1  6 MHz system clock; all logic on its rising edge.
REQ-003 Port: rstz  in  1  reset, synchronous, active-low.
REQ-004 Port: start_p  in  1  one-cycle burst request, sampled only in IDLE.
REQ-005 Port: stop_p  in  1  one-cycle abort request.
REQ-006 Port: dir  in  1  burst direction, 1=TX, 0=RX; latched with start_p.
REQ-007 Port: chan  in  7  RF channel index, legal 0..78; latched with start_p.
REQ-008 Port: nbits  in  10  burst length in bits, legal 1..1023; latched with start_p.
REQ-009 Port: txbyte / txbyte_vld / txbyte_rdy  in 8 / in 1 / out 1  TX byte stream; transfer on vld&&rdy.
REQ-010 Port: rxbyte / rxbyte_vld  out 8 / out 1  RX byte stream; vld is a one-cycle pulse, no backpressure.
REQ-011 Port: k  out  7  channel to radio; loadfreq_p  out  1  one-cycle retune strobe.
REQ-012 Port: txen / rxen / txbitin  out 1 / out 1 / out 1  radio enables and TX bit.
REQ-013 Port: rxbitout  in  1  RX bit from radio.
REQ-014 Port: busy / done_p / err_p  out 1 / out 1 / out 1  status, completion pulse, error pulse.

Function
REQ-015 States: IDLE, LOAD, SETTLE, XFER, DONE; busy=1 in every state except IDLE.
REQ-016 IDLE + start_p with chan<=78 and nbits!=0: latch dir/chan/nbits, go to LOAD; otherwise err_p pulses one cycle and the block stays in IDLE.
REQ-017 LOAD lasts 1 cycle: loadfreq_p=1, k=latched chan; k holds that value until the next accepted start.
REQ-018 SETTLE lasts exactly SETTLE_CYC cycles, then XFER; with start_p sampled in cycle 0, txen/rxen first go high in cycle SETTLE_CYC+2.
REQ-019 XFER: bit period is 6 cycles (1 Mb/s); txen=dir, rxen=!dir, held for nbits*6 cycles.
REQ-020 TX: one-byte holding buffer; txbyte_rdy = busy && dir && buffer empty, so prefill during LOAD/SETTLE is allowed; bits are sent LSB first and txbitin is held for the full bit period.
REQ-021 TX underrun: if a new byte is needed at a bit boundary and the buffer is empty, err_p pulses, txen drops, and the block returns to IDLE without done_p.
REQ-022 RX: rxbitout is sampled in cycle 3 (0-based) of each bit period, assembled LSB first; rxbyte_vld pulses the cycle after the 8th sample of each byte.
REQ-023 RX partial final byte (nbits%8!=0): emitted after the last sample, right-aligned, unused upper bits 0.
REQ-024 After the last bit period: DONE for 1 cycle, txen=rxen=0, done_p=1, then IDLE.
REQ-025 stop_p in any non-IDLE state: IDLE next cycle, enables drop, no done_p/err_p, partial RX byte discarded; stop_p in IDLE has no effect.
REQ-026 start_p while busy is ignored; start_p and stop_p together in IDLE: start accepted.
REQ-027 txbitin=0 whenever txen=0.

Reset
REQ-028 rstz=0 at a clk_6M edge: state IDLE; k=0; loadfreq_p, txen, rxen, txbitin, txbyte_rdy, rxbyte_vld, busy, done_p, err_p all 0; rxbyte=0; counters and buffer cleared.
REQ-029 Reset mid-burst takes effect on the same edge; nothing is emitted afterwards.

Configuration
REQ-030 Macro BT_RADIO_SEQ_WHITEN_EN: when defined, TX and RX bits are XORed with a 7-bit LFSR x^7+x^4+1, seeded {1'b1,chan[5:0]} in LOAD and stepped once per bit; when undefined, bits pass unmodified.

Verification
REQ-031 SETTLE_CYC=600, start dir=1 chan=5 nbits=8, txbyte=0xA5 prefilled -> loadfreq_p at cycle 1 with k=5; txen at cycle 602; txbitin 1,0,1,0,0,1,0,1 with 6 cycles each; done_p at cycle 650.
REQ-032 RX chan=78 nbits=12, radio bits 0xF3C LSB first -> rxbyte 0x3C, then 0x0F; then done_p.
REQ-033 start with chan=79, or with nbits=0 -> err_p one cycle, busy stays 0, loadfreq_p never asserted.
REQ-034 TX nbits=16, second byte withheld -> err_p at the 9th bit boundary, txen drops, no done_p.
REQ-035 stop_p during SETTLE, then rstz=0 during RX XFER -> IDLE, all outputs 0 next cycle, no rxbyte_vld.
REQ-036 BT_RADIO_SEQ_WHITEN_EN defined, TX nbits=8 0x00 on chan=0 -> txbitin equals the first 8 LFSR output bits from seed 7'h40.
